// File: rtl/wb_dmem_slave.sv
// Wishbone B4 classic-cycle data memory slave.
// It range-checks each request, inserts a fixed wait, applies byte-lane writes and returns one ack or err.
module wb_dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] SPAN  = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              err_flag_q, err_flag_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdat_q, rdat_d;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req_c;
  logic [32:0]       off_c;
  logic              addr_err_c;
  logic [IDX_W-1:0]  addr_idx_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  t_idx_c;
  logic [31:0]       t_dat_c;
  logic [3:0]        t_sel_c;
  logic              t_we_c;
  logic              t_err_c;

  // Address decode; an address below the base wraps to a huge offset, so one compare covers both bounds.
  always_comb begin
    req_c      = wbs_cyc_i & wbs_stb_i;
    off_c      = {1'b0, wbs_addr_i} - {1'b0, BASE_ADDR};
    addr_err_c = (wbs_addr_i[1:0] != 2'b00) | (off_c >= SPAN);
    addr_idx_c = off_c[IDX_W+1:2];
  end

  // With no wait states the response edge is also the capture edge, so live inputs stand in for the captures.
  always_comb begin
    if (state_q == ST_IDLE) begin
      t_idx_c = addr_idx_c;
      t_dat_c = wbs_dat_i;
      t_sel_c = wbs_sel_i;
      t_we_c  = wbs_we_i;
      t_err_c = addr_err_c;
    end else begin
      t_idx_c = idx_q;
      t_dat_c = wdat_q;
      t_sel_c = sel_q;
      t_we_c  = we_q;
      t_err_c = err_flag_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      err_flag_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      err_flag_q <= err_flag_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
    end
  end

  // Next state and the response that becomes visible on the edge entering RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    err_flag_d = err_flag_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdat_d     = '0;
    mem_we_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          idx_d      = addr_idx_c;
          wdat_d     = wbs_dat_i;
          sel_d      = wbs_sel_i;
          we_d       = wbs_we_i;
          err_flag_d = addr_err_c;
          cnt_d      = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_RESP && state_q != ST_RESP) begin
      if (t_err_c) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (t_we_c) begin
          mem_we_c = 1'b1;
        end else begin
          rdat_d = mem[t_idx_c];
        end
      end
    end
  end

  // Memory array is deliberately left out of reset; writes are blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (mem_we_c && rst_i) begin
      for (int b = 0; b < 4; b++) begin
        if (t_sel_c[b]) begin
          mem[t_idx_c][8*b +: 8] <= t_dat_c[8*b +: 8];
        end
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_dmem_slave.sv
// Bench for wb_dmem_slave: four instances with different wait/base/depth settings,
// directed scenarios plus random traffic checked against a word/byte-mask memory model.
module tb_wb_dmem_slave;

  localparam int unsigned NI = 4;

  function automatic int unsigned wc_of(input int unsigned k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 0;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned dep_of(input int unsigned k);
    return (k == 3) ? 16 : 1024;
  endfunction

  function automatic logic [31:0] base_of(input int unsigned k);
    return (k == 3) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   cyc;
  logic            stb, we;
  logic [3:0]      sel;
  logic [31:0]     addr, wdat;
  logic [NI-1:0]   ack, err;
  logic [31:0]     rdat [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_dmem_slave #(
      .DEPTH_WORDS(dep_of(g)),
      .BASE_ADDR  (base_of(g)),
      .WAIT_CYCLES(wc_of(g))
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .wbs_cyc_i (cyc[g]),
      .wbs_stb_i (stb),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_addr_i(addr),
      .wbs_dat_i (wdat),
      .wbs_dat_o (rdat[g]),
      .wbs_ack_o (ack[g]),
      .wbs_err_o (err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_msk [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input int unsigned k, input logic [31:0] a);
    longint unsigned la, lb, le;
    la = 64'(a);
    lb = 64'(base_of(k));
    le = lb + 64'(4 * dep_of(k));
    return (a[1:0] != 2'b00) || (la < lb) || (la >= le);
  endfunction

  function automatic int ref_key(input int unsigned k, input logic [31:0] a);
    logic [31:0] off;
    off = a - base_of(k);
    return int'(k) * 65536 + int'(off >> 2);
  endfunction

  // One complete classic-cycle transfer with exact latency and one-cycle pulse checks.
  task automatic do_txn(input int unsigned k, input bit w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input string tag,
                        output logic [31:0] rd);
    bit e;
    int key;
    e = ref_err(k, a);
    @(negedge clk);
    cyc = '0; cyc[k] = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdat = d;
    @(posedge clk);
    for (int i = 0; i < int'(wc_of(k)); i++) begin
      #1;
      check({tag, "_wait"}, {30'd0, ack[k], err[k]}, 32'd0);
      @(posedge clk);
    end
    #1;
    check({tag, "_ack"}, 32'(ack[k]), 32'(!e));
    check({tag, "_err"}, 32'(err[k]), 32'(e));
    rd = rdat[k];
    if (e) begin
      check({tag, "_errdat"}, rdat[k], 32'd0);
    end else begin
      key = ref_key(k, a);
      if (!w && ref_msk.exists(key))
        check({tag, "_data"}, rdat[k] & ref_msk[key], ref_mem[key] & ref_msk[key]);
      if (w) begin
        if (!ref_msk.exists(key)) begin
          ref_mem[key] = 32'd0;
          ref_msk[key] = 32'd0;
        end
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            ref_mem[key][8*b +: 8] = d[8*b +: 8];
            ref_msk[key][8*b +: 8] = 8'hFF;
          end
        end
      end
    end
    cyc = '0; stb = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {30'd0, ack[k], err[k]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    logic [31:0] b2b_exp [4];
    int n;

    rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wdat = '0;
    #1;
    for (int k = 0; k < int'(NI); k++)
      check("reset_out", {rdat[k][31:2], ack[k], err[k]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read
    do_txn(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, "t1_wr", rd);
    do_txn(0, 1'b0, 32'h10, 4'hF, 32'h0, "t1_rd", rd);
    check("t1_value", rd, 32'hDEAD_BEEF);

    // Byte lanes
    do_txn(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, "t2_wr", rd);
    do_txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, "t2_lane", rd);
    do_txn(0, 1'b0, 32'h20, 4'h0, 32'h0, "t2_rd", rd);
    check("t2_value", rd, 32'h11BB_33DD);

    // Error terminations and the top word
    do_txn(0, 1'b0, 32'h0000_1002, 4'hF, 32'h0, "t3_misal", rd);
    do_txn(0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, "t3_range", rd);
    do_txn(0, 1'b1, 32'h0000_0FFC, 4'hF, 32'h5, "t3_topwr", rd);
    do_txn(0, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0, "t3_toprd", rd);
    check("t3_value", rd, 32'h5);
    do_txn(3, 1'b0, 32'h7FFF_FFFC, 4'hF, 32'h0, "t3_below", rd);
    do_txn(3, 1'b0, 32'h8000_0040, 4'hF, 32'h0, "t3_above", rd);
    do_txn(3, 1'b1, 32'h8000_003C, 4'hF, 32'h600D_CAFE, "t3_hiwr", rd);
    do_txn(3, 1'b0, 32'h8000_003C, 4'hF, 32'h0, "t3_hird", rd);
    check("t3_hivalue", rd, 32'h600D_CAFE);

    // Abort in WAIT
    do_txn(1, 1'b1, 32'h40, 4'hF, 32'h0, "t4_pre", rd);
    @(negedge clk);
    cyc = '0; cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h40; wdat = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    cyc = '0; stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t4_quiet", {30'd0, ack[1], err[1]}, 32'd0);
    end
    do_txn(1, 1'b0, 32'h40, 4'hF, 32'h0, "t4_rd", rd);
    check("t4_value", rd, 32'h0);

    // Back-to-back reads with strobe held
    for (int i = 0; i < 4; i++) begin
      b2b_exp[i] = $urandom;
      do_txn(2, 1'b1, 32'(4 * i), 4'hF, b2b_exp[i], "t5_pre", rd);
    end
    @(negedge clk);
    cyc = '0; cyc[2] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("t5_noerr", 32'(err[2]), 32'd0);
      if (ack[2]) begin
        check("t5_cycle", 32'(c), 32'(2 * n));
        if (n < 4) check("t5_data", rdat[2], b2b_exp[n]);
        n++;
        if (n < 4) addr = 32'(4 * n);
        else begin cyc = '0; stb = 1'b0; end
      end
    end
    cyc = '0; stb = 1'b0;
    check("t5_count", 32'(n), 32'd4);

    // Asynchronous reset while ack is high
    @(negedge clk);
    cyc = '0; cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h10;
    @(posedge clk); @(posedge clk); #1;
    check("t6_ackhi", {ack[0], rdat[0][30:0]}, {1'b1, 31'h5EAD_BEEF});
    #2 rst_n = 1'b0;
    #1;
    check("t6_async", {rdat[0][31:2], ack[0], err[0]}, 32'd0);
    cyc = '0; stb = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // Reset in the middle of a waited write
    do_txn(1, 1'b1, 32'h80, 4'hF, 32'hCAFE_F00D, "t6_pre", rd);
    @(negedge clk);
    cyc = '0; cyc[1] = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h80; wdat = 32'h0BAD_0BAD;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_midwait", {rdat[1][31:2], ack[1], err[1]}, 32'd0);
    cyc = '0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_txn(1, 1'b0, 32'h80, 4'hF, 32'h0, "t6_rd", rd);
    check("t6_value", rd, 32'hCAFE_F00D);

    // Random traffic on every instance
    for (int k = 0; k < int'(NI); k++) begin
      for (int t = 0; t < 60; t++) begin
        int unsigned r, idx, lim;
        lim = (dep_of(k) > 32) ? 32 : dep_of(k);
        r   = $urandom_range(0, 9);
        idx = $urandom_range(0, lim - 1);
        case (r)
          0:       a = base_of(k) + 32'(4 * idx) + 32'($urandom_range(1, 3));
          1:       a = base_of(k) + 32'(4 * dep_of(k)) + 32'(4 * $urandom_range(0, 3));
          2:       a = base_of(k) - 32'(4 * $urandom_range(1, 4));
          default: a = base_of(k) + 32'(4 * idx);
        endcase
        d = $urandom;
        do_txn(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), d, "rnd", rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
